// File: rtl/branch_set_ctrl_if.sv
// EX-stage condition/branch bundle between the pipeline (master) and branch_set_ctrl (slave).
interface branch_set_ctrl_if;
  logic        ex_valid;
  logic        ex_is_br;
  logic        ex_is_set;
  logic [1:0]  br_typ;
  logic [1:0]  set_typ;
  logic        zero;
  logic        neg;
  logic        ofl;
  logic [15:0] br_target;
  logic        stall_in;
  logic [15:0] set_out;
  logic        set_valid;
  logic        pc_redirect;
  logic [15:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic [15:0] br_taken_cnt;
  logic [15:0] br_total_cnt;

  modport master (
    output ex_valid, ex_is_br, ex_is_set, br_typ, set_typ, zero, neg, ofl, br_target, stall_in,
    input  set_out, set_valid, pc_redirect, redirect_pc, flush_ifid, flush_idex,
           br_taken_cnt, br_total_cnt
  );

  modport slave (
    input  ex_valid, ex_is_br, ex_is_set, br_typ, set_typ, zero, neg, ofl, br_target, stall_in,
    output set_out, set_valid, pc_redirect, redirect_pc, flush_ifid, flush_idex,
           br_taken_cnt, br_total_cnt
  );
endinterface

// File: rtl/branch_set_ctrl.sv
// EX-stage branch/set condition controller with predict-not-taken redirect and flush sequencing.
// Optional branch performance counters are enabled by defining BRC_PERF_CNT_EN.
module branch_set_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  branch_set_ctrl_if.slave bus
);
  typedef enum logic {IDLE, FLUSH} state_t;

  localparam int CW = 3;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          taken;
  logic          cond;
  logic          acc;
  logic          br_acc;
  logic          set_acc;

  always_comb begin
    taken = 1'b0;
    case (bus.br_typ)
      2'b00: taken = bus.zero;
      2'b01: taken = ~bus.zero;
      2'b10: taken = bus.neg;
      2'b11: taken = ~bus.neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (bus.set_typ)
      2'b00: cond = bus.zero;
      2'b01: cond = bus.neg;
      2'b10: cond = bus.neg | bus.zero;
      2'b11: cond = bus.ofl;
      default: cond = 1'b0;
    endcase
  end

  // Wrong-path instructions are ignored while flushing because acc requires IDLE.
  assign acc     = bus.ex_valid & ~bus.stall_in & (state == IDLE);
  assign br_acc  = acc & bus.ex_is_br;
  assign set_acc = acc & bus.ex_is_set & ~bus.ex_is_br;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.set_out     <= '0;
      bus.set_valid   <= 1'b0;
      bus.pc_redirect <= 1'b0;
      bus.redirect_pc <= '0;
      bus.flush_ifid  <= 1'b0;
      bus.flush_idex  <= 1'b0;
    end else begin
      bus.set_valid   <= set_acc;
      bus.pc_redirect <= 1'b0;
      if (set_acc) bus.set_out <= {15'b0, cond};
      case (state)
        IDLE: begin
          if (br_acc && taken) begin
            state           <= FLUSH;
            cnt             <= CNT_LOAD;
            bus.pc_redirect <= 1'b1;
            bus.redirect_pc <= bus.br_target;
            bus.flush_ifid  <= 1'b1;
            bus.flush_idex  <= 1'b1;
          end
        end
        FLUSH: begin
          // Counts down regardless of stall_in: the squash window is fixed length.
          if (cnt == '0) begin
            state          <= IDLE;
            bus.flush_ifid <= 1'b0;
            bus.flush_idex <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRC_PERF_CNT_EN
  logic [15:0] taken_cnt;
  logic [15:0] total_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
      total_cnt <= '0;
    end else if (br_acc) begin
      if (total_cnt != 16'hFFFF) total_cnt <= total_cnt + 16'd1;
      if (taken && taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
    end
  end

  assign bus.br_taken_cnt = taken_cnt;
  assign bus.br_total_cnt = total_cnt;
`else
  assign bus.br_taken_cnt = 16'h0000;
  assign bus.br_total_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_set_ctrl.sv
// Self-checking bench for branch_set_ctrl: cycle table through a scoreboard plus flush/saturation sequences.
module tb_branch_set_ctrl;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_set_ctrl_if bus ();

  branch_set_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r, v, br, st;
    logic [1:0]  bt, stt;
    logic        z, n, o;
    logic [15:0] tgt;
    logic        stall;
    logic [15:0] e_so;
    logic        e_sv, e_pr;
    logic [15:0] e_rpc;
    logic        e_fl;
    logic [15:0] e_tk, e_tot;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] so;
    logic        sv, pr;
    logic [15:0] rpc;
    logic        fl;
    logic [15:0] tk, tot;
  } exp_t;

  localparam int NV = 30;
  vec_t tbl [NV];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    rst           = t.r;
    bus.ex_valid  = t.v;
    bus.ex_is_br  = t.br;
    bus.ex_is_set = t.st;
    bus.br_typ    = t.bt;
    bus.set_typ   = t.stt;
    bus.zero      = t.z;
    bus.neg       = t.n;
    bus.ofl       = t.o;
    bus.br_target = t.tgt;
    bus.stall_in  = t.stall;
  endtask

  task automatic idle_in();
    bus.ex_valid = 0; bus.ex_is_br = 0; bus.ex_is_set = 0; bus.br_typ = 0; bus.set_typ = 0;
    bus.zero = 0; bus.neg = 0; bus.ofl = 0; bus.br_target = 0; bus.stall_in = 0;
  endtask

  // Scoreboard consumer: each entry describes outputs one edge after its stimulus.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      string p;
      e = sb.pop_front();
      p = $sformatf("row%0d", e.idx);
      chk({p, ".set_out"},     bus.set_out,     e.so);
      chk({p, ".set_valid"},   bus.set_valid,   e.sv);
      chk({p, ".pc_redirect"}, bus.pc_redirect, e.pr);
      chk({p, ".redirect_pc"}, bus.redirect_pc, e.rpc);
      chk({p, ".flush_ifid"},  bus.flush_ifid,  e.fl);
      chk({p, ".flush_idex"},  bus.flush_idex,  e.fl);
`ifdef BRC_PERF_CNT_EN
      chk({p, ".br_taken_cnt"}, bus.br_taken_cnt, e.tk);
      chk({p, ".br_total_cnt"}, bus.br_total_cnt, e.tot);
`else
      chk({p, ".br_taken_cnt"}, bus.br_taken_cnt, 16'h0000);
      chk({p, ".br_total_cnt"}, bus.br_total_cnt, 16'h0000);
`endif
    end
  end

  initial begin
    int nfl;
    // r v br st  bt stt z n o tgt      stall | set_out sv pr rpc fl tk tot
    tbl[0]  = '{1,0,0,0, 0,0, 0,0,0, 16'h0000,0, 16'h0000,0,0,16'h0000,0, 0,0};
    tbl[1]  = '{1,0,0,0, 0,0, 0,0,0, 16'h0000,0, 16'h0000,0,0,16'h0000,0, 0,0};
    tbl[2]  = '{0,1,0,1, 0,2, 0,1,0, 16'h0000,0, 16'h0001,1,0,16'h0000,0, 0,0}; // SLE neg
    tbl[3]  = '{0,1,0,1, 0,2, 0,0,0, 16'h0000,0, 16'h0000,1,0,16'h0000,0, 0,0}; // SLE false
    tbl[4]  = '{0,1,0,1, 0,0, 1,0,0, 16'h0000,0, 16'h0001,1,0,16'h0000,0, 0,0}; // SEQ
    tbl[5]  = '{0,1,0,1, 0,3, 0,0,1, 16'h0000,0, 16'h0001,1,0,16'h0000,0, 0,0}; // SCO
    tbl[6]  = '{0,1,0,1, 0,1, 1,0,0, 16'h0000,0, 16'h0000,1,0,16'h0000,0, 0,0}; // SLT false
    tbl[7]  = '{0,0,0,0, 0,0, 1,0,0, 16'h0000,0, 16'h0000,0,0,16'h0000,0, 0,0};
    tbl[8]  = '{0,1,0,1, 0,0, 1,0,0, 16'h0000,1, 16'h0000,0,0,16'h0000,0, 0,0}; // stalled set
    tbl[9]  = '{0,0,0,1, 0,0, 1,0,0, 16'h0000,0, 16'h0000,0,0,16'h0000,0, 0,0}; // invalid set
    tbl[10] = '{0,1,0,1, 0,0, 1,0,0, 16'h0000,0, 16'h0001,1,0,16'h0000,0, 0,0};
    tbl[11] = '{0,1,1,0, 3,0, 0,1,0, 16'h1234,0, 16'h0001,0,0,16'h0000,0, 0,1}; // BGEZ not taken
    tbl[12] = '{0,1,1,0, 3,0, 0,0,0, 16'h1234,1, 16'h0001,0,0,16'h0000,0, 0,1}; // stalled taken
    tbl[13] = '{0,1,1,0, 0,0, 1,0,0, 16'h00A4,0, 16'h0001,0,1,16'h00A4,1, 1,2}; // BEQZ taken
    tbl[14] = '{0,1,0,1, 0,0, 1,0,0, 16'h0000,0, 16'h0001,0,0,16'h00A4,1, 1,2}; // set squashed
    tbl[15] = '{0,1,1,0, 1,0, 0,0,0, 16'h5555,0, 16'h0001,0,0,16'h00A4,0, 1,2}; // wrong-path br
    tbl[16] = '{0,1,1,0, 2,0, 0,1,0, 16'h0BEE,0, 16'h0001,0,1,16'h0BEE,1, 2,3}; // BLTZ as flush drops
    tbl[17] = '{1,0,0,0, 0,0, 0,0,0, 16'h0000,0, 16'h0000,0,0,16'h0000,0, 0,0}; // reset mid-flush
    tbl[18] = '{0,0,0,0, 0,0, 0,0,0, 16'h0000,0, 16'h0000,0,0,16'h0000,0, 0,0};
    tbl[19] = '{0,1,1,0, 1,0, 0,0,0, 16'h00C8,0, 16'h0000,0,1,16'h00C8,1, 1,1}; // BNEZ taken
    tbl[20] = '{0,0,0,0, 0,0, 0,0,0, 16'h0000,0, 16'h0000,0,0,16'h00C8,1, 1,1};
    tbl[21] = '{0,0,0,0, 0,0, 0,0,0, 16'h0000,0, 16'h0000,0,0,16'h00C8,0, 1,1};
    tbl[22] = '{0,1,1,1, 0,3, 0,0,1, 16'h0077,0, 16'h0000,0,0,16'h00C8,0, 1,2}; // br+set, not taken
    tbl[23] = '{0,1,1,1, 3,0, 1,0,0, 16'h0102,0, 16'h0000,0,1,16'h0102,1, 2,3}; // br+set, taken
    tbl[24] = '{0,0,0,0, 0,0, 0,0,0, 16'h0000,0, 16'h0000,0,0,16'h0102,1, 2,3};
    tbl[25] = '{0,0,0,0, 0,0, 0,0,0, 16'h0000,0, 16'h0000,0,0,16'h0102,0, 2,3};
    tbl[26] = '{0,1,1,0, 0,0, 1,0,0, 16'h0F0F,0, 16'h0000,0,1,16'h0F0F,1, 3,4};
    tbl[27] = '{0,1,0,1, 0,0, 1,0,0, 16'h0000,1, 16'h0000,0,0,16'h0F0F,1, 3,4}; // stall in flush
    tbl[28] = '{0,1,0,0, 0,0, 0,0,0, 16'h0000,1, 16'h0000,0,0,16'h0F0F,0, 3,4};
    tbl[29] = '{0,1,1,0, 2,0, 0,0,0, 16'h3333,0, 16'h0000,0,0,16'h0F0F,0, 3,5}; // BLTZ not taken

    rst = 1'b1;
    idle_in();
    for (int i = 0; i < NV; i++) begin
      exp_t e;
      @(negedge clk);
      drive(tbl[i]);
      e.idx = i; e.so = tbl[i].e_so; e.sv = tbl[i].e_sv; e.pr = tbl[i].e_pr;
      e.rpc = tbl[i].e_rpc; e.fl = tbl[i].e_fl; e.tk = tbl[i].e_tk; e.tot = tbl[i].e_tot;
      sb.push_back(e);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    @(posedge clk); #2;
    chk("sb_drained", sb.size(), 0);

    // Flush window length measured directly, bounded.
    @(negedge clk);
    bus.ex_valid = 1; bus.ex_is_br = 1; bus.br_typ = 2'b00; bus.zero = 1; bus.br_target = 16'h1357;
    @(negedge clk);
    idle_in();
    chk("seq.pc_redirect", bus.pc_redirect, 1);
    chk("seq.redirect_pc", bus.redirect_pc, 16'h1357);
    nfl = 0;
    for (int i = 0; i < 20 && bus.flush_ifid; i++) begin
      nfl++;
      @(posedge clk); #1;
    end
    chk("seq.flush_timeout", bus.flush_ifid, 0);
    chk("seq.flush_len", nfl, FC);
    chk("seq.redirect_hold", bus.redirect_pc, 16'h1357);

`ifdef BRC_PERF_CNT_EN
    // Saturation: more than 2^16 not-taken branches.
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    bus.ex_valid = 1; bus.ex_is_br = 1; bus.br_typ = 2'b01; bus.zero = 1;
    for (int i = 0; i < 65540; i++) @(negedge clk);
    idle_in();
    chk("sat.br_total_cnt", bus.br_total_cnt, 16'hFFFF);
    chk("sat.br_taken_cnt", bus.br_taken_cnt, 16'h0000);
`else
    chk("nocnt.br_total_cnt", bus.br_total_cnt, 16'h0000);
    chk("nocnt.br_taken_cnt", bus.br_taken_cnt, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
